data_memory_bsel: RTL and testbench
===================================

Name: data_memory_bsel

Overview:
- Parametrised successor to the MIPS data memory. It adds byte, halfword and word access with sign/zero extension, little-endian byte lanes and misalignment detection.
- Also adds a multi-cycle flush state machine that clears one word per cycle and reports itself busy.
- Sits in the MEM stage and keeps the full-contents debug bus for the debug/UART unit.

Parameters:
- ADDR_SIZE, 5, word-address bits; depth = 2**ADDR_SIZE words.
- SLOT_SIZE, 32, word width in bits; power of two, at least 32.
- BYTE_BITS, clog2(SLOT_SIZE/8), derived, byte-offset bits inside a word; not overridable.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_flush  in  1  one-cycle request to start a clear of the whole memory.
- i_wr_rd  in  1  1 = write this cycle, 0 = read.
- i_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- i_signed  in  1  on reads, 1 = sign-extend, 0 = zero-extend; ignored for word reads and for writes.
- i_addr  in  ADDR_SIZE+BYTE_BITS  byte address; upper ADDR_SIZE bits = word index, low BYTE_BITS = byte offset.
- i_data  in  SLOT_SIZE  write data, right-aligned (byte in [7:0], half in [15:0]).
- o_data  out  SLOT_SIZE  read data, extended.
- o_busy  out  1  high while the flush is in progress.
- o_misaligned  out  1  illegal or misaligned access on the current inputs.
- o_bus_debug  out  2**ADDR_SIZE*SLOT_SIZE  all words, word k at [k*SLOT_SIZE +: SLOT_SIZE].

Behaviour:
- Reset (i_reset=0, asynchronous): all words 0, FSM in IDLE, flush counter 0, o_busy 0. o_data therefore reads 0. Reset is honoured in any state, including mid-flush.
- Byte lanes are little-endian: byte at offset k occupies bits [8k+7:8k].
- Halfword at offset h occupies [8h+15:8h].
- Alignment rules:
  - Byte: always aligned.
  - Half: offset must be even.
  - Word: offset must be 0.
  - i_size=11: always illegal.
- o_misaligned is combinational from i_size and i_addr, and is evaluated in every cycle regardless of i_wr_rd.
- Read (combinational, zero latency):
  - Select the addressed word, shift the selected lane down to bit 0, then extend to SLOT_SIZE according to i_signed.
  - Misaligned read or o_busy=1: o_data = 0.
- Write (synchronous): on the rising edge with i_wr_rd=1, o_misaligned=0 and o_busy=0, only the addressed lane bytes are updated from the low bytes of i_data; other bytes and words are untouched.
  - Misaligned write: suppressed; memory is unchanged.
  - Write while busy: dropped, not queued.
- Flush FSM, IDLE -> CLEAR -> IDLE:
  - IDLE: on an edge with i_flush=1, go to CLEAR with counter 0; o_busy rises after that edge.
  - CLEAR: each edge zeroes word[counter] and increments the counter. After the edge that clears word 2**ADDR_SIZE-1, return to IDLE with the counter wrapped to 0.
  - o_busy is high for exactly 2**ADDR_SIZE cycles.
  - i_flush asserted during CLEAR: ignored, no restart, no extension.
  - i_flush and i_wr_rd both high in IDLE: flush wins and the write is dropped.
- The debug bus reflects memory contents after each edge, including partial flush progress.
- Address wrap: the word index covers the full range. There is no out-of-range address; the top byte address maps to the last word.

Test Plan:
(All scenarios use ADDR_SIZE=5, SLOT_SIZE=32, 7-bit byte address.)
- Word and sub-word reads: after reset, write word 0xDEADBEEF at addr 0x04, then read:
  - word 0x04 -> 0xDEADBEEF.
  - signed byte 0x05 -> 0xFFFFFFBE.
  - unsigned byte 0x07 -> 0x000000DE.
  - signed half 0x06 -> 0xFFFFDEAD.
  - unsigned half 0x04 -> 0x0000BEEF.
- Byte write: word 2 = 0x11223344; write byte 0x12 at addr 0x09 -> word 2 = 0x11221244, debug slots 0/1/3 unchanged. Then write half 0xABCD at 0x0A -> word 2 = 0xABCD1244.
- Misalignment:
  - Half write 0xAAAA at 0x03 -> o_misaligned=1 in the same cycle; word 0 unchanged.
  - Word read at 0x0A -> o_misaligned=1, o_data=0.
  - i_size=11 at 0x00 -> o_misaligned=1.
- Flush: fill all 32 words with 0xFFFFFFFF and pulse i_flush.
  - o_busy is high for exactly 32 cycles.
  - A write of 0x5A5A5A5A to word 31 during cycle 3 of busy is dropped.
  - A second i_flush pulse at busy cycle 10 does not extend busy.
  - Afterwards all debug words = 0.
- Reset mid-flush: drive i_reset low at busy cycle 10 -> o_busy=0 immediately (asynchronous) and all words 0. Release reset, write 0x1 at 0x00, flush again -> 32 busy cycles, word 0 = 0.
- Top address: write word 0xCAFEF00D at 0x7C -> debug slot 31 = 0xCAFEF00D; unsigned byte read at 0x7F -> 0x000000CA.

Source files
------------

// File: rtl/data_memory_bsel.sv
// Byte-addressable MEM-stage data memory: byte/half/word access with sign/zero extension,
// little-endian lanes, misalignment detection, a one-word-per-cycle flush FSM and a full debug bus.
module data_memory_bsel #(
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned SLOT_SIZE = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_flush,
    input  logic                                  i_wr_rd,
    input  logic [1:0]                            i_size,
    input  logic                                  i_signed,
    input  logic [ADDR_SIZE+$clog2(SLOT_SIZE/8)-1:0] i_addr,
    input  logic [SLOT_SIZE-1:0]                  i_data,
    output logic [SLOT_SIZE-1:0]                  o_data,
    output logic                                  o_busy,
    output logic                                  o_misaligned,
    output logic [(2**ADDR_SIZE)*SLOT_SIZE-1:0]   o_bus_debug
);

    localparam int unsigned BYTE_BITS = $clog2(SLOT_SIZE / 8);
    localparam int unsigned NBYTES    = SLOT_SIZE / 8;
    localparam int unsigned DEPTH     = 2 ** ADDR_SIZE;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t                 r_state;
    logic [ADDR_SIZE-1:0]   r_cnt;
    logic                   r_busy;
    logic [SLOT_SIZE-1:0]   r_mem [DEPTH];

    logic [ADDR_SIZE-1:0]   w_widx;
    logic [BYTE_BITS-1:0]   w_off;
    logic [BYTE_BITS+2:0]   w_shamt;
    logic [SLOT_SIZE-1:0]   w_word;
    logic [SLOT_SIZE-1:0]   w_lane;
    logic [SLOT_SIZE-1:0]   w_wdata;
    logic [NBYTES-1:0]      w_be_base;
    logic [NBYTES-1:0]      w_be;
    logic                   w_mis;

    assign w_widx  = i_addr[ADDR_SIZE+BYTE_BITS-1:BYTE_BITS];
    assign w_off   = i_addr[BYTE_BITS-1:0];
    assign w_shamt = {w_off, 3'b000};
    assign w_word  = r_mem[w_widx];
    assign w_lane  = w_word >> w_shamt;
    assign w_wdata = i_data << w_shamt;
    assign w_be    = w_be_base << w_off;

    always_comb begin
        w_mis     = 1'b0;
        w_be_base = '0;
        case (i_size)
            2'b00: w_be_base = NBYTES'(1);
            2'b01: begin
                w_be_base = NBYTES'(3);
                w_mis     = w_off[0];
            end
            2'b10: begin
                w_be_base = '1;
                w_mis     = (w_off != '0);
            end
            default: w_mis = 1'b1;
        endcase
    end

    assign o_misaligned = w_mis;
    assign o_busy       = r_busy;

    always_comb begin
        o_data = '0;
        if (!w_mis && !r_busy) begin
            case (i_size)
                2'b00:   o_data = {{(SLOT_SIZE-8){i_signed & w_lane[7]}}, w_lane[7:0]};
                2'b01:   o_data = {{(SLOT_SIZE-16){i_signed & w_lane[15]}}, w_lane[15:0]};
                default: o_data = w_word;
            endcase
        end
    end

    always_comb begin
        o_bus_debug = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            o_bus_debug[k*SLOT_SIZE +: SLOT_SIZE] = r_mem[k];
        end
    end

    // Flush has priority over a same-cycle write; writes are only accepted in IDLE.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_flush) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (i_wr_rd && !w_mis) begin
                        for (int unsigned b = 0; b < NBYTES; b++) begin
                            if (w_be[b]) begin
                                r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
                            end
                        end
                    end
                end
                ST_CLEAR: begin
                    r_mem[r_cnt] <= '0;
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_bsel.sv
// Directed scoreboard bench for data_memory_bsel (ADDR_SIZE=5, SLOT_SIZE=32).
module tb_data_memory_bsel;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         wr_rd;
    logic [1:0]   size;
    logic         sgn;
    logic [6:0]   addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         busy;
    logic         mis;
    logic [1023:0] dbg;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    always #5 clk = ~clk;

    data_memory_bsel #(.ADDR_SIZE(5), .SLOT_SIZE(32)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_flush      (flush),
        .i_wr_rd      (wr_rd),
        .i_size       (size),
        .i_signed     (sgn),
        .i_addr       (addr),
        .i_data       (wdata),
        .o_data       (rdata),
        .o_busy       (busy),
        .o_misaligned (mis),
        .o_bus_debug  (dbg)
    );

    function automatic logic [31:0] slot(input int k);
        return dbg[k*32 +: 32];
    endfunction

    task automatic push(input string tag, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        e = sb_q.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic drv(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [6:0] a, input logic [31:0] d, input logic fl);
        @(negedge clk);
        wr_rd = w;
        size  = sz;
        sgn   = sg;
        addr  = a;
        wdata = d;
        flush = fl;
    endtask

    task automatic idle();
        drv(1'b0, 2'b10, 1'b0, 7'h00, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] sz, input logic [6:0] a, input logic [31:0] d);
        drv(1'b1, sz, 1'b0, a, d, 1'b0);
        idle();
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sz, input logic sg,
                          input logic [6:0] a, input logic [31:0] exp);
        drv(1'b0, sz, sg, a, 32'h0, 1'b0);
        push(tag, exp);
        #2;
        chk(rdata);
    endtask

    task automatic dbg_chk(input string tag, input int k, input logic [31:0] exp);
        push(tag, exp);
        chk(slot(k));
    endtask

    task automatic count_busy(output int n);
        n = 0;
        drv(1'b0, 2'b10, 1'b0, 7'h00, 32'h0, 1'b1);
        for (int c = 0; c < 100; c++) begin
            idle();
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        flush = 1'b0;
        wr_rd = 1'b0;
        size  = 2'b10;
        sgn   = 1'b0;
        addr  = '0;
        wdata = '0;

        #12;
        push("reset_busy", 32'h0);
        chk({31'b0, busy});
        push("reset_rdata", 32'h0);
        chk(rdata);
        for (int k = 0; k < 32; k++) dbg_chk("reset_slot", k, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        wr(2'b10, 7'h04, 32'hDEADBEEF);
        rd_chk("rd_word_04",   2'b10, 1'b0, 7'h04, 32'hDEADBEEF);
        rd_chk("rd_sbyte_05",  2'b00, 1'b1, 7'h05, 32'hFFFFFFBE);
        rd_chk("rd_ubyte_07",  2'b00, 1'b0, 7'h07, 32'h000000DE);
        rd_chk("rd_shalf_06",  2'b01, 1'b1, 7'h06, 32'hFFFFDEAD);
        rd_chk("rd_uhalf_04",  2'b01, 1'b0, 7'h04, 32'h0000BEEF);
        rd_chk("rd_word_sgn",  2'b10, 1'b1, 7'h04, 32'hDEADBEEF);

        wr(2'b10, 7'h08, 32'h11223344);
        wr(2'b00, 7'h09, 32'hFFFFFF12);
        dbg_chk("bytewr_slot2", 2, 32'h11221244);
        dbg_chk("bytewr_slot0", 0, 32'h0);
        dbg_chk("bytewr_slot1", 1, 32'hDEADBEEF);
        dbg_chk("bytewr_slot3", 3, 32'h0);
        wr(2'b01, 7'h0A, 32'h9999ABCD);
        dbg_chk("halfwr_slot2", 2, 32'hABCD1244);

        wr(2'b10, 7'h00, 32'h01020304);
        drv(1'b1, 2'b01, 1'b0, 7'h03, 32'h0000AAAA, 1'b0);
        push("mis_half_03", 32'h1);
        #2;
        chk({31'b0, mis});
        idle();
        dbg_chk("mis_wr_slot0", 0, 32'h01020304);
        drv(1'b0, 2'b10, 1'b0, 7'h0A, 32'h0, 1'b0);
        push("mis_word_0A", 32'h1);
        #2;
        chk({31'b0, mis});
        push("mis_word_rdata", 32'h0);
        chk(rdata);
        drv(1'b0, 2'b11, 1'b0, 7'h00, 32'h0, 1'b0);
        push("mis_size11", 32'h1);
        #2;
        chk({31'b0, mis});
        drv(1'b0, 2'b01, 1'b0, 7'h02, 32'h0, 1'b0);
        push("aligned_half_02", 32'h0);
        #2;
        chk({31'b0, mis});
        rd_chk("rd_uhalf_02", 2'b01, 1'b0, 7'h02, 32'h00000102);

        wr(2'b10, 7'h7C, 32'hCAFEF00D);
        dbg_chk("top_slot31", 31, 32'hCAFEF00D);
        rd_chk("rd_ubyte_7F", 2'b00, 1'b0, 7'h7F, 32'h000000CA);

        for (int k = 0; k < 32; k++) wr(2'b10, 7'(k * 4), 32'hFFFFFFFF);
        dbg_chk("fill_slot17", 17, 32'hFFFFFFFF);
        n = 0;
        drv(1'b0, 2'b10, 1'b0, 7'h00, 32'h0, 1'b1);
        for (int c = 0; c < 100; c++) begin
            idle();
            if (!busy) break;
            n++;
            if (n == 3) begin
                wr_rd = 1'b1;
                addr  = 7'h7C;
                wdata = 32'h5A5A5A5A;
            end
            if (n == 5) begin
                addr = 7'h7C;
                push("busy_rdata", 32'h0);
                #2;
                chk(rdata);
            end
            if (n == 10) flush = 1'b1;
            if (n == 20) begin
                dbg_chk("partial_slot0", 0, 32'h0);
                dbg_chk("partial_slot31", 31, 32'hFFFFFFFF);
            end
        end
        push("flush_busy_cycles", 32'd32);
        chk(32'(n));
        for (int k = 0; k < 32; k++) dbg_chk("flush_slot", k, 32'h0);

        wr(2'b10, 7'h14, 32'h12345678);
        n = 0;
        drv(1'b0, 2'b10, 1'b0, 7'h00, 32'h0, 1'b1);
        for (int c = 0; c < 100; c++) begin
            idle();
            if (!busy) break;
            n++;
            if (n == 10) begin
                rst_n = 1'b0;
                #1;
                push("rst_mid_busy", 32'h0);
                chk({31'b0, busy});
                dbg_chk("rst_mid_slot5", 5, 32'h0);
                dbg_chk("rst_mid_slot31", 31, 32'h0);
                break;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr(2'b10, 7'h00, 32'h00000001);
        dbg_chk("post_rst_slot0", 0, 32'h1);
        count_busy(n);
        push("reflush_busy_cycles", 32'd32);
        chk(32'(n));
        dbg_chk("reflush_slot0", 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
